// File: rtl/mux_nto1_rr_if.sv
// Handshake bundle for mux_nto1_rr: N producer channels in, one consumer channel out.
// The master modport is the environment side and the slave modport is the mux side.
interface mux_nto1_rr_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = 2
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic               mode;
   logic [SELW-1:0]    sel;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_chan;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/mux_nto1_rr.sv
// N-to-1 registered multiplexer with valid/ready on every channel.
// The source is chosen either by an explicit select or by round-robin arbitration.
module mux_nto1_rr #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   mux_nto1_rr_if.slave        if_mux
);

   logic [WIDTH-1:0] r_out_data;
   logic [SELW-1:0]  r_out_chan;
   logic             r_out_valid;
   logic [SELW-1:0]  r_ptr;

   logic             w_load_en;
   logic             w_grant_vld;
   logic [SELW-1:0]  w_grant_idx;
   logic [WIDTH-1:0] w_grant_data;
   logic [N-1:0]     w_in_ready;
   logic [SELW-1:0]  w_next_ptr;

   assign w_load_en = ~r_out_valid | if_mux.out_ready;

   // Grant selection: manual compare against sel, or round-robin starting at r_ptr
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = {SELW{1'b0}};
      if (if_mux.mode) begin
         // Channels below r_ptr are the wrap-around fallback; channels at or above
         // r_ptr override them. Descending order leaves the lowest index in each group.
         for (int i = N - 1; i >= 0; i--) begin
            if (if_mux.in_valid[i] && (SELW'(i) < r_ptr)) begin
               w_grant_vld = 1'b1;
               w_grant_idx = SELW'(i);
            end else begin
               w_grant_vld = w_grant_vld;
            end
         end
         for (int i = N - 1; i >= 0; i--) begin
            if (if_mux.in_valid[i] && (SELW'(i) >= r_ptr)) begin
               w_grant_vld = 1'b1;
               w_grant_idx = SELW'(i);
            end else begin
               w_grant_vld = w_grant_vld;
            end
         end
      end else begin
         // sel values of N and above match no channel, so they give no grant
         for (int i = 0; i < N; i++) begin
            if (if_mux.in_valid[i] && (SELW'(i) == if_mux.sel)) begin
               w_grant_vld = 1'b1;
               w_grant_idx = SELW'(i);
            end else begin
               w_grant_vld = w_grant_vld;
            end
         end
      end
   end

   // Data steering and per-channel ready for the granted index
   always_comb begin
      w_grant_data = {WIDTH{1'b0}};
      w_in_ready   = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (w_grant_idx == SELW'(i)) begin
            w_grant_data  = if_mux.in_data[i*WIDTH +: WIDTH];
            w_in_ready[i] = rst_n & w_load_en & w_grant_vld;
         end else begin
            w_in_ready[i] = 1'b0;
         end
      end
   end

   // Pointer advance after a round-robin grant, wrapping past N-1
   always_comb begin
      if (w_grant_idx == SELW'(N - 1)) begin
         w_next_ptr = {SELW{1'b0}};
      end else begin
         w_next_ptr = w_grant_idx + SELW'(1);
      end
   end

   // Output register and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= {WIDTH{1'b0}};
         r_out_chan  <= {SELW{1'b0}};
         r_out_valid <= 1'b0;
         r_ptr       <= {SELW{1'b0}};
      end else if (w_load_en) begin
         if (w_grant_vld) begin
            r_out_data  <= w_grant_data;
            r_out_chan  <= w_grant_idx;
            r_out_valid <= 1'b1;
            if (if_mux.mode) begin
               r_ptr <= w_next_ptr;
            end
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign if_mux.in_ready  = w_in_ready;
   assign if_mux.out_data  = r_out_data;
   assign if_mux.out_chan  = r_out_chan;
   assign if_mux.out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr: the driver predicts accepted words from a queue-based
// reference model, and an independent monitor checks each word as the consumer takes it.
module tb_mux_nto1_rr;
   localparam int WIDTH = 8;
   localparam int N     = 4;
   localparam int SELW  = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux_nto1_rr_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus_if ();

   mux_nto1_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .if_mux (bus_if)
   );

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SELW-1:0]  chan;
   } word_t;

   int    checks   = 0;
   int    failures = 0;
   word_t exp_q[$];
   int    m_ptr    = 0;
   bit    m_valid  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: the first requesting channel in priority order, or -1 for none
   function automatic int model_grant(input logic [N-1:0] v, input bit md, input int s);
      if (!md) begin
         if (s < N && v[s]) return s;
         return -1;
      end
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic step(input logic [N-1:0] v, input logic [N*WIDTH-1:0] d, input bit md,
                       input logic [SELW-1:0] s, input bit rdy);
      int          g;
      bit          load;
      logic [31:0] exp_ready;
      @(negedge clk);
      bus_if.in_valid  = v;
      bus_if.in_data   = d;
      bus_if.mode      = md;
      bus_if.sel       = s;
      bus_if.out_ready = rdy;
      #1;
      g         = model_grant(v, md, int'(s));
      load      = !m_valid || rdy;
      exp_ready = (load && g >= 0) ? (32'd1 << g) : 32'd0;
      check("in_ready", 32'(bus_if.in_ready), exp_ready);
      check("out_valid", 32'(bus_if.out_valid), 32'(m_valid));
      @(posedge clk);
      if (load) begin
         if (g >= 0) begin
            exp_q.push_back({WIDTH'(d >> (g * WIDTH)), SELW'(g)});
            m_valid = 1'b1;
            if (md) m_ptr = (g + 1) % N;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic do_reset(input int cyc);
      @(negedge clk);
      rst_n            = 1'b0;
      bus_if.in_valid  = {N{1'b1}};
      bus_if.in_data   = $urandom;
      bus_if.mode      = 1'b1;
      bus_if.sel       = {SELW{1'b0}};
      bus_if.out_ready = 1'b1;
      exp_q.delete();
      m_valid = 1'b0;
      m_ptr   = 0;
      repeat (cyc) begin
         #1;
         check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
         check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
         check("rst_out_data", 32'(bus_if.out_data), 32'd0);
         check("rst_out_chan", 32'(bus_if.out_chan), 32'd0);
         @(negedge clk);
      end
      bus_if.in_valid = {N{1'b0}};
      rst_n           = 1'b1;
   endtask

   // Monitor: whenever the consumer takes a word, it must be the oldest predicted one
   initial begin
      word_t w;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n === 1'b1 && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got data %0h chan %0d expected no word",
                        bus_if.out_data, bus_if.out_chan);
            end else begin
               w = exp_q.pop_front();
               check("out_data", 32'(bus_if.out_data), 32'(w.data));
               check("out_chan", 32'(bus_if.out_chan), 32'(w.chan));
            end
         end
      end
   end

   localparam logic [N*WIDTH-1:0] FAIR_DATA = 32'h33221100;

   initial begin
      rst_n            = 1'b0;
      bus_if.in_valid  = {N{1'b0}};
      bus_if.in_data   = {(N*WIDTH){1'b0}};
      bus_if.mode      = 1'b0;
      bus_if.sel       = {SELW{1'b0}};
      bus_if.out_ready = 1'b0;

      do_reset(3);

      // Round-robin fairness from reset: channels 0,1,2,3,0
      repeat (5) step(4'hF, FAIR_DATA, 1'b1, 3'd0, 1'b1);

      // Manual select of channel 2, then an out-of-range select
      repeat (3) step(4'hF, FAIR_DATA, 1'b0, 3'd2, 1'b1);
      repeat (2) step(4'hF, FAIR_DATA, 1'b0, 3'd5, 1'b1);

      // Backpressure for three cycles, then drain-and-load on one edge
      step(4'hF, FAIR_DATA, 1'b1, 3'd0, 1'b1);
      repeat (3) step(4'hF, $urandom, 1'b1, 3'd0, 1'b0);
      step(4'hF, $urandom, 1'b1, 3'd0, 1'b1);
      step(4'h0, $urandom, 1'b1, 3'd0, 1'b1);

      // Sparse requests and wrap-around
      step(4'b0001, FAIR_DATA, 1'b1, 3'd0, 1'b1);
      step(4'b0001, FAIR_DATA, 1'b1, 3'd0, 1'b1);
      step(4'b1001, FAIR_DATA, 1'b1, 3'd0, 1'b1);
      step(4'b1001, FAIR_DATA, 1'b1, 3'd0, 1'b1);

      // Mode switch keeps the round-robin pointer
      step(4'b0010, FAIR_DATA, 1'b1, 3'd0, 1'b1);
      repeat (2) step(4'hF, FAIR_DATA, 1'b0, 3'd0, 1'b1);
      step(4'hF, FAIR_DATA, 1'b1, 3'd0, 1'b1);

      // Reset while a word is held under backpressure
      step(4'hF, $urandom, 1'b1, 3'd0, 1'b0);
      step(4'hF, $urandom, 1'b1, 3'd0, 1'b0);
      do_reset(2);

      // Randomized traffic
      repeat (600) begin
         step(N'($urandom), $urandom, 1'($urandom_range(1)), SELW'($urandom),
              ($urandom_range(3) != 0));
      end

      repeat (3) step(4'h0, $urandom, 1'b1, 3'd0, 1'b1);
      @(negedge clk);
      #3;
      check("drained_queue", 32'(exp_q.size()), 32'(m_valid));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
